// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam int          FETCH_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]            instr;
    logic [FETCH_WIDTH-1:0] pc;
    logic [FETCH_WIDTH-1:0] pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side bundle: instruction-memory port, execute redirect and decode handshake.
interface fetch_queue_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic [31:0]      imem_rdata;
  logic             PCsrc_E;
  logic [WIDTH-1:0] PCTarget_E;
  logic             valid_D;
  logic             ready_D;
  logic [31:0]      instr_D;
  logic [WIDTH-1:0] PC_D;
  logic [WIDTH-1:0] PCPlus4_D;

  modport master (
    output imem_req, imem_addr, valid_D, instr_D, PC_D, PCPlus4_D,
    input  imem_rdata, PCsrc_E, PCTarget_E, ready_D
  );

  modport slave (
    input  imem_req, imem_addr, valid_D, instr_D, PC_D, PCPlus4_D,
    output imem_rdata, PCsrc_E, PCTarget_E, ready_D
  );
endinterface

// File: rtl/fetch_queue_fifo.sv
// fq_fifo: circular buffer of fetch entries with push/pop/flush and an occupancy count.
module fq_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  entry_t                     push_data,
  output entry_t                     head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: the storage array carries no reset; only pointers and count do, and
  // the head is masked while empty so nothing unwritten ever reaches a port.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: PC register, credit-throttled imem requests and squash on redirect,
// feeding fq_fifo. Define FETCH_QUEUE_STATS_EN to add stall_cnt/flush_cnt outputs.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   flush_cnt
`endif
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // fetch_entry_t layout, sized to this instance's WIDTH.
  typedef struct packed {
    logic [31:0]      instr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
  } entry_t;

  logic [WIDTH-1:0] pc_f;
  logic [WIDTH-1:0] req_pc;
  logic             inflight;
  logic             push;
  logic             pop;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] credit_used;
  entry_t           push_data;
  entry_t           head;

  // An outstanding request reserves a slot until its response lands, so the
  // queue can never be pushed while full.
  assign credit_used   = count + CNT_W'(inflight);
  assign bus.imem_req  = rst && !bus.PCsrc_E && (credit_used < CNT_W'(DEPTH));
  assign bus.imem_addr = pc_f;

  assign push        = inflight && !bus.PCsrc_E;
  assign bus.valid_D = !empty && !bus.PCsrc_E;
  assign pop         = bus.valid_D && bus.ready_D;
  assign push_data   = '{instr: bus.imem_rdata, pc: req_pc, pc_plus4: req_pc + WIDTH'(4)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_f     <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      // imem_req is low during a redirect, so the slot after it starts empty.
      inflight <= bus.imem_req;
      if (bus.imem_req) req_pc <= pc_f;
      if (bus.PCsrc_E)       pc_f <= bus.PCTarget_E & ~WIDTH'(3);
      else if (bus.imem_req) pc_f <= pc_f + WIDTH'(4);
    end
  end

  fq_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (bus.PCsrc_E),
    .push_data (push_data),
    .head      (head),
    .empty     (empty),
    .count     (count)
  );

  assign bus.instr_D   = head.instr;
  assign bus.PC_D      = head.pc;
  assign bus.PCPlus4_D = head.pc_plus4;

`ifdef FETCH_QUEUE_STATS_EN
  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.valid_D && !bus.ready_D && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (bus.PCsrc_E && flush_cnt != '1)                 flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: WIDTH, 32, datapath/address width.
REQ-002 Parameter: DEPTH, 4, queue entries (power of two, >=2).
REQ-003 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low; the ports SHALL be named clk and rst.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 imem_req  output  1  instruction-memory read strobe.
REQ-008 imem_addr  output  WIDTH  read address, word aligned.
REQ-009 imem_rdata  input  32  read data, valid exactly one cycle after imem_req.
REQ-010 PCsrc_E  input  1  redirect from execute.
REQ-011 PCTarget_E  input  WIDTH  redirect target.
REQ-012 valid_D  output  1  head entry is presented to decode.
REQ-013 ready_D  input  1  decode accepts head (low = stall).
REQ-014 instr_D, PC_D, PCPlus4_D  output  32/WIDTH/WIDTH  head entry fields.

Function
REQ-015 Fetch PC register PC_F SHALL drive imem_addr; PC_F advances by 4 in every cycle imem_req=1 and PCsrc_E=0, wrapping modulo 2^WIDTH.
REQ-016 imem_req SHALL be 1 only when count + inflight < DEPTH and PCsrc_E=0 (credit rule; queue never overflows).
REQ-017 A response SHALL be pushed as {imem_rdata, requesting PC, PC+4} in the cycle after its request unless squashed.
REQ-018 valid_D SHALL equal (queue not empty) AND NOT PCsrc_E; the head pops when valid_D and ready_D are both 1.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; push while full is impossible under REQ-016.
REQ-020 Redirect (PCsrc_E=1) SHALL, at that clock edge: empty the queue, squash any in-flight response, load PC_F with {PCTarget_E[WIDTH-1:2],2'b00}; redirect has priority over push and pop.
REQ-021 Latency: first request in the cycle after reset release; valid_D=1 two cycles later; after a redirect in cycle t, target requested in t+1, valid_D=1 in t+3.
REQ-022 Queue order SHALL be strict FIFO; pointers wrap modulo DEPTH.
REQ-023 Outputs instr_D/PC_D/PCPlus4_D are don't-care while valid_D=0.

Reset
REQ-024 On rst=0: PC_F=RESET_PC, count=0, inflight=0, valid_D=0, imem_req=0, instr_D/PC_D/PCPlus4_D=0.
REQ-025 Reset asserted mid-operation SHALL discard queue and in-flight data immediately; the response cycle after release SHALL NOT push.

Configuration
REQ-026 Macro FETCH_QUEUE_STATS_EN: when defined, add outputs stall_cnt (32, increments each cycle valid_D=1 and ready_D=0) and flush_cnt (32, increments per redirect), both saturating at all-ones and reset to 0; when undefined, neither port nor counter exists and behaviour is otherwise identical.

Structure
REQ-027 Package fetch_pkg SHALL hold typedef fetch_entry_t {instr, pc, pc_plus4} and constant NOP_INSTR=32'h0000_0013.
REQ-028 Storage SHALL be a sub-module fq_fifo (parameterised DEPTH, entry type fetch_entry_t, push/pop/flush, count output); fetch_queue holds PC, credit and squash logic.

Verification
REQ-029 Reset release, ready_D=1, imem returns 0x00A00093 at 0x0 -> valid_D=1 two cycles after release with PC_D=0x0, PCPlus4_D=0x4, instr_D=0x00A00093.
REQ-030 ready_D=0 for 10 cycles, DEPTH=4 -> exactly 4 entries buffered (PC 0x0..0xC), imem_req=0 once credits exhausted, stall_cnt=10 with FETCH_QUEUE_STATS_EN.
REQ-031 Full queue, PCsrc_E=1 with PCTarget_E=0x0000_0102 -> next imem_addr=0x100, valid_D=0 for 2 cycles, then PC_D=0x100; no stale entry appears.
REQ-032 Redirect in the cycle after a request -> the response of that request is not pushed; flush_cnt increments by 1.
REQ-033 RESET_PC=0xFFFF_FFF8, free-running -> PC_D sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4.
REQ-034 rst pulsed low while queue holds 3 entries -> valid_D=0 immediately, first post-reset PC_D=RESET_PC.
